rv32_muldiv_seq: RTL and testbench
==================================

RV32_MULDIV_SEQ -- requirements
Module: rv32_muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand/result width (32 or 64).
REQ-002 SHALL have parameter TAG_W, default 5, giving the destination-register tag width.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1, which kills any operation in flight.
REQ-006 SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1), the request handshake.
REQ-007 SHALL have port op_i, input, 3, carrying the M-extension funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have ports rs1_i and rs2_i, input, XLEN, the operands.
REQ-009 SHALL have port tag_i, input, TAG_W, the rd tag carried through to the response.
REQ-010 SHALL have ports resp_valid_o (output, 1) and resp_ready_i (input, 1), the response handshake.
REQ-011 SHALL have ports result_o (output, XLEN) and tag_o (output, TAG_W), the response data.
REQ-012 SHALL have port busy_o, output, 1, high whenever the FSM is not IDLE, for the hazard unit's stall logic.

Function
REQ-013 SHALL implement FSM states IDLE, DIV, FIX and DONE.
REQ-014 SHALL drive req_ready_o high only in IDLE, registered with no combinational path from flush_i.
REQ-015 SHALL accept a request in IDLE when req_valid_i=1 and flush_i=0, latching op, operands and tag.
REQ-016 SHALL, on a multiply op, go IDLE->DONE with the result registered, so resp_valid_o rises at N+1 for acceptance at cycle N.
REQ-017 SHALL return the low XLEN bits of the product for MUL, and the high XLEN bits with signed×signed, signed×unsigned or unsigned×unsigned operands for MULH, MULHSU and MULHU.
REQ-018 SHALL, on a divide op, go IDLE->DIV and run XLEN restoring iterations (1 quotient bit per cycle), then spend one FIX cycle on sign correction, then enter DONE, so resp_valid_o rises at N+XLEN+2.
REQ-019 SHALL use an iteration counter of clog2(XLEN) bits that counts down from XLEN-1 and leaves DIV on reaching 0.
REQ-020 SHALL perform signed divides on magnitudes: quotient negated when the operand signs differ, remainder taking the sign of the dividend.
REQ-021 SHALL, on divide by zero, return a quotient of all ones and a remainder equal to rs1.
REQ-022 SHALL, on signed overflow (-2^(XLEN-1) / -1), return a quotient equal to rs1 and a remainder of 0.
REQ-023 SHALL, in DONE, hold result_o and tag_o stable until resp_ready_i=1, then go to IDLE on the next cycle; a new request is never accepted in that same cycle.
REQ-024 SHALL, when flush_i=1 in any state, go to IDLE the next cycle, deassert resp_valid_o and drop the result; a request presented alongside flush_i is not accepted.
REQ-025 SHALL give flush_i priority over a resp_valid_o/resp_ready_i handshake in the same cycle, and that response is treated as discarded.

Reset
REQ-026 SHALL, while rst_i=1 at a clk_i edge, set state=IDLE, resp_valid_o=0, result_o=0, tag_o=0, busy_o=0 and counter=0.
REQ-027 SHALL let reset abort a DIV mid-operation, with req_ready_o=1 on the first cycle after reset is released.

Configuration
REQ-028 SHALL, with macro MULDIV_EARLY_OUT_EN defined, route divide by zero, signed overflow and rs1=0 divides IDLE->DONE so the response appears at N+1.
REQ-029 SHALL, without MULDIV_EARLY_OUT_EN, take the full XLEN+2 latency on every divide while still producing the REQ-021/022 results.

Structure
REQ-030 SHALL take a muldiv_op_e enum (funct3 encodings) and a muldiv_state_e enum from the shared defines package, alongside the existing ALU/exception widths.
REQ-031 SHALL place the one-bit restoring step (shift, trial subtract, select) in a combinational sub-module rv32_div_iter parametrised by XLEN.

Verification
REQ-032 SHALL have a directed test: MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB, resp_valid_o at N+1.
REQ-033 SHALL have a directed test: MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 SHALL have a directed test: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, resp_valid_o at N+34, tag echoed.
REQ-035 SHALL have a directed test: DIVU 0x1234 / 0 -> 0xFFFFFFFF and REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; response at N+1 with MULDIV_EARLY_OUT_EN, N+34 without.
REQ-036 SHALL have a directed test: flush_i at N+10 during DIV -> no resp_valid_o, and req_ready_o=1 at N+11.
REQ-037 SHALL have a directed test: resp_ready_i held 0 for 5 cycles in DONE -> result_o/tag_o stable and req_ready_o=0 throughout, with IDLE one cycle after the handshake.

Source files
------------

// File: rtl/rv32_muldiv_seq_pkg.sv
// Shared M-extension defines: funct3 op encodings, muldiv FSM states, and
// the ALU/exception widths used across the execute stage.
package rv32_muldiv_seq_pkg;

    localparam int ALU_OP_W    = 4;
    localparam int EXC_CAUSE_W = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/rv32_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module rv32_div_iter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          q_bit;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, dvs_i};
        q_bit   = ~diff[XLEN];
        rem_o   = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], q_bit};
    end

endmodule

// File: rtl/rv32_muldiv_seq.sv
// Sequential RV32/64 M-extension unit: single-cycle multiply, XLEN-cycle
// restoring divide. Define MULDIV_EARLY_OUT_EN to short-cut trivial divides.
//
// state   | meaning
// IDLE    | ready for a request
// DIV     | one restoring quotient bit per cycle, counter counts down
// FIX     | sign correction and divide-by-zero / overflow results
// DONE    | response held until resp_ready_i
module rv32_muldiv_seq
    import rv32_muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(XLEN);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    muldiv_state_e   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q, rs1_q;
    logic [XLEN-1:0] rem_nxt, quo_nxt;
    logic            is_rem_q, dz_q, ovf_q, neg_q_q, neg_r_q;

    muldiv_op_e      op_in;
    logic            is_div_in, is_rem_in, signed_in;
    logic            rs1_neg, rs2_neg, dz_in, ovf_in, early_in;
    logic            mul_a_sign, mul_b_sign;
    logic [XLEN-1:0] mag1, mag2, mul_res;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        op_in      = muldiv_op_e'(op_i);
        is_div_in  = op_i[2];
        is_rem_in  = op_i[1];
        signed_in  = (op_in == OP_DIV) || (op_in == OP_REM);
        rs1_neg    = signed_in & rs1_i[XLEN-1];
        rs2_neg    = signed_in & rs2_i[XLEN-1];
        mag1       = rs1_neg ? -rs1_i : rs1_i;
        mag2       = rs2_neg ? -rs2_i : rs2_i;
        dz_in      = (rs2_i == '0);
        ovf_in     = signed_in && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        early_in   = dz_in || ovf_in || (rs1_i == '0);

        mul_a_sign = ((op_in == OP_MULH) || (op_in == OP_MULHSU)) & rs1_i[XLEN-1];
        mul_b_sign = (op_in == OP_MULH) & rs2_i[XLEN-1];
        // Sign-extended operands make one unsigned 2*XLEN multiply serve all variants.
        prod       = {{XLEN{mul_a_sign}}, rs1_i} * {{XLEN{mul_b_sign}}, rs2_i};
        mul_res    = (op_in == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    rv32_div_iter #(.XLEN(XLEN)) u_div_iter (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nxt),
        .quo_o (quo_nxt)
    );

    function automatic logic [XLEN-1:0] div_result(
        input logic            is_rem,
        input logic            dz,
        input logic            ovf,
        input logic            neg_q,
        input logic            neg_r,
        input logic [XLEN-1:0] dividend,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r
    );
        if (dz)
            return is_rem ? dividend : '1;
        if (ovf)
            return is_rem ? '0 : dividend;
        if (is_rem)
            return neg_r ? -r : r;
        return neg_q ? -q : q;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            resp_valid_o <= 1'b0;
            result_o     <= '0;
            tag_o        <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            rs1_q        <= '0;
            is_rem_q     <= 1'b0;
            dz_q         <= 1'b0;
            ovf_q        <= 1'b0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
        end else if (flush_i) begin
            state_q      <= ST_IDLE;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            resp_valid_o <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        tag_o       <= tag_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        rs1_q       <= rs1_i;
                        is_rem_q    <= is_rem_in;
                        dz_q        <= dz_in;
                        ovf_q       <= ovf_in;
                        neg_q_q     <= rs1_neg ^ rs2_neg;
                        neg_r_q     <= rs1_neg;
                        if (!is_div_in) begin
                            result_o     <= mul_res;
                            resp_valid_o <= 1'b1;
                            state_q      <= ST_DONE;
                        end else if (EARLY_OUT && early_in) begin
                            result_o     <= div_result(is_rem_in, dz_in, ovf_in, 1'b0, 1'b0,
                                                       rs1_i, '0, '0);
                            resp_valid_o <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= mag1;
                            dvs_q   <= mag2;
                            cnt_q   <= CNT_W'(XLEN-1);
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt_q == '0)
                        state_q <= ST_FIX;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    result_o     <= div_result(is_rem_q, dz_q, ovf_q, neg_q_q, neg_r_q,
                                               rs1_q, quo_q, rem_q);
                    resp_valid_o <= 1'b1;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        busy_o       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_muldiv_seq.sv
// Scoreboard bench for rv32_muldiv_seq: directed vectors with hand-computed results.
module tb_rv32_muldiv_seq;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  tag = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  rtag;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    rv32_muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .op_i         (op),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .tag_i        (tag),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .result_o     (result),
        .tag_o        (rtag),
        .busy_o       (busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency on first valid cycle, data/stability every valid cycle.
    bit prev_valid = 1'b0;
    bit hs_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            hs_prev    = 1'b0;
        end else begin
            if (hs_prev) begin
                checks++;
                if (!(req_ready && !resp_valid && !busy)) begin
                    errors++;
                    $display("FAIL idle_after_hs ready=%0b valid=%0b busy=%0b want 1/0/0",
                             req_ready, resp_valid, busy);
                end
            end
            hs_prev = 1'b0;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_resp result=%h tag=%0d want no response", result, rtag);
                end else begin
                    if (!prev_valid) begin
                        checks++;
                        if (cyc - sb[0].acc != sb[0].lat) begin
                            errors++;
                            $display("FAIL latency got N+%0d want N+%0d", cyc - sb[0].acc, sb[0].lat);
                        end
                    end
                    checks++;
                    if (req_ready) begin
                        errors++;
                        $display("FAIL ready_in_done got 1 want 0");
                    end
                    checks++;
                    if (result !== sb[0].res || rtag !== sb[0].tag) begin
                        errors++;
                        $display("FAIL resp_data result=%h tag=%0d want %h tag=%0d",
                                 result, rtag, sb[0].res, sb[0].tag);
                    end
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end
            prev_valid = resp_valid;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] exp_res, input int lat,
                         input bit expect_resp);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout req_ready=0 want 1");
            return;
        end
        op = o; rs1 = a; rs2 = b; tag = t; req_valid = 1'b1;
        acc_cyc = cyc;
        if (expect_resp) sb.push_back('{exp_res, t, lat, cyc});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_tag", {27'd0, rtag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        issue(3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 1, 1'b1); drain();
        issue(3'b000, 32'h12345678, 32'h10,       5'd4,  32'h23456780, 1, 1'b1); drain();
        issue(3'b001, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 1, 1'b1); drain();
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1, 1'b1); drain();
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 1, 1'b1); drain();
        issue(3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, DIV_LAT, 1'b1); drain();
        issue(3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, DIV_LAT, 1'b1); drain();
        issue(3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       DIV_LAT, 1'b1); drain();
        issue(3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        DIV_LAT, 1'b1); drain();
        issue(3'b100, 32'd7,        32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, DIV_LAT, 1'b1); drain();
        issue(3'b110, 32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        DIV_LAT, 1'b1); drain();
        issue(3'b101, 32'hFFFFFFFF, 32'd1,        5'd15, 32'hFFFFFFFF, DIV_LAT, 1'b1); drain();
        issue(3'b111, 32'hFFFFFFFF, 32'h10,       5'd16, 32'hF,        DIV_LAT, 1'b1); drain();
        issue(3'b101, 32'h1234,     32'd0,        5'd17, 32'hFFFFFFFF, EARLY_LAT, 1'b1); drain();
        issue(3'b111, 32'h1234,     32'd0,        5'd18, 32'h1234,     EARLY_LAT, 1'b1); drain();
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, EARLY_LAT, 1'b1); drain();
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        EARLY_LAT, 1'b1); drain();
        issue(3'b100, 32'hFFFFFFFB, 32'd0,        5'd21, 32'hFFFFFFFF, EARLY_LAT, 1'b1); drain();
        issue(3'b110, 32'hFFFFFFFB, 32'd0,        5'd22, 32'hFFFFFFFB, EARLY_LAT, 1'b1); drain();
        issue(3'b101, 32'd0,        32'd5,        5'd23, 32'd0,        EARLY_LAT, 1'b1); drain();
        issue(3'b111, 32'd0,        32'd5,        5'd24, 32'd0,        EARLY_LAT, 1'b1); drain();

        // Response held off for five DONE cycles.
        resp_ready = 1'b0;
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd25, 32'hFFFFFFFE, 1, 1'b1);
        begin
            int n = 0;
            while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        end
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
        drain();

        // Flush mid-divide.
        issue(3'b100, 32'd1000, 32'd3, 5'd26, 32'd0, 0, 1'b0);
        @(negedge clk);
        while (cyc < acc_cyc + 10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_ready", {31'd0, req_ready}, 32'd1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_no_resp", {31'd0, resp_valid}, 32'd0);

        // Request alongside flush is not accepted.
        op = 3'b000; rs1 = 32'd3; rs2 = 32'd3; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_req_busy", {31'd0, busy}, 32'd0);
        check("flush_req_valid", {31'd0, resp_valid}, 32'd0);

        // Reset aborts a divide.
        issue(3'b101, 32'd1000, 32'd3, 5'd27, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_abort_ready", {31'd0, req_ready}, 32'd1);
        check("rst_abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("rst_abort_no_resp", {31'd0, resp_valid}, 32'd0);

        issue(3'b100, 32'd1000, 32'd3, 5'd28, 32'd333, DIV_LAT, 1'b1); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
